cdb_arbiter: RTL and testbench

- Arbitrates the single Common Data Bus between result producers: ALU/ReservationStation path (src 0) and LoadStoreBuffer load path (src 1).
- Each source owns a small FIFO that absorbs results which lose arbitration.
- One winner per cycle, chosen round-robin, is broadcast on a registered CDB to ReorderBuffer, ReservationStation, LoadStoreBuffer and RegisterFile.
- Sits between the execution units and the ROB commit side; replaces ad-hoc direct result wiring.

---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/cdb_src_fifo.sv | 54 +++++
 rtl/cdb_arbiter.sv | 144 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the Common Data Bus arbiter.
// Source index constants name the fixed producers on the CDB.
package cdb_arbiter_pkg;

    localparam int CDB_SRC_ALU = 0;
    localparam int CDB_SRC_LSB = 1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [0:0] {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

    // Width of a source index; at least one bit even for a single source.
    function automatic int cdb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: absorbs results that lose CDB arbitration.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_o && !clear_i;
    assign pop_ok  = pop_i && !empty_o && !clear_i;

    // Pointer update; clear discards every buffered entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Entry storage; no reset needed since pointers qualify contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one round-robin winner per cycle among the
// result sources, broadcast on a registered CDB.
// Optional feature macro: CDB_BYPASS_EN (empty-FIFO source may go straight
// to the broadcast register, giving 1-cycle latency).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int DEPTH     = 2,
    parameter int ROB_TAG_W = 4,
    parameter int XLEN      = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          rdy_in,
    input  logic                                          clear_in,
    input  logic [NUM_SRC-1:0]                            src_valid_in,
    input  logic [NUM_SRC*ROB_TAG_W-1:0]                  src_tag_in,
    input  logic [NUM_SRC*XLEN-1:0]                       src_value_in,
    output logic [NUM_SRC-1:0]                            src_ready_out,
    output logic                                          cdb_valid_out,
    output logic [ROB_TAG_W-1:0]                          cdb_tag_out,
    output logic [XLEN-1:0]                               cdb_value_out,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] cdb_src_out
);

    localparam int SW = cdb_idx_w(NUM_SRC);
    localparam int EW = ROB_TAG_W + XLEN;

    logic [EW-1:0]        in_entry [NUM_SRC];
    logic [EW-1:0]        head     [NUM_SRC];
    logic [NUM_SRC-1:0]   full;
    logic [NUM_SRC-1:0]   empty;
    logic [NUM_SRC-1:0]   push;
    logic [NUM_SRC-1:0]   pop;
    logic [NUM_SRC-1:0]   cand;
    logic                 advance;
    logic                 grant_vld;
    logic [SW-1:0]        grant_idx;
    logic [EW-1:0]        win_entry;
    logic                 win_bypass;

    logic [SW-1:0]        rr_q;
    logic                 valid_q;
    logic [ROB_TAG_W-1:0] tag_q;
    logic [XLEN-1:0]      value_q;
    logic [SW-1:0]        src_q;

    assign advance       = rdy_in && !clear_in;
    assign src_ready_out = ~full;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            assign in_entry[g] = {src_tag_in[g*ROB_TAG_W +: ROB_TAG_W],
                                  src_value_in[g*XLEN +: XLEN]};

            cdb_src_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (EW)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .clear_i (clear_in),
                .push_i  (push[g]),
                .pop_i   (pop[g]),
                .wdata_i (in_entry[g]),
                .rdata_o (head[g]),
                .full_o  (full[g]),
                .empty_o (empty[g])
            );
        end
    endgenerate

    // Candidate set: buffered sources, plus idle sources presenting a result when bypass is built in.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
`ifdef CDB_BYPASS_EN
            cand[i] = !empty[i] || (src_valid_in[i] && !full[i]);
`else
            cand[i] = !empty[i];
`endif
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(rr_q) + k) % NUM_SRC;
            if (!grant_vld && cand[idx]) begin
                grant_vld = 1'b1;
                grant_idx = SW'(idx);
            end
        end
    end

    // Winner data and FIFO strobes; a bypassed result is never written to its FIFO.
    always_comb begin
        win_entry  = head[grant_idx];
        win_bypass = 1'b0;
`ifdef CDB_BYPASS_EN
        if (empty[grant_idx]) begin
            win_entry  = in_entry[grant_idx];
            win_bypass = 1'b1;
        end
`endif
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pop[i]  = advance && grant_vld && (grant_idx == SW'(i)) && !empty[i];
            push[i] = advance && src_valid_in[i] && !full[i]
                      && !(grant_vld && (grant_idx == SW'(i)) && win_bypass);
        end
    end

    // Broadcast register and round-robin pointer; clear wins over rdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            value_q <= '0;
            src_q   <= '0;
            rr_q    <= SW'(NUM_SRC - 1);
        end else if (clear_in) begin
            valid_q <= 1'b0;
        end else if (rdy_in) begin
            valid_q <= grant_vld;
            if (grant_vld) begin
                tag_q   <= win_entry[EW-1:XLEN];
                value_q <= win_entry[XLEN-1:0];
                src_q   <= grant_idx;
                rr_q    <= grant_idx;
            end
        end
    end

    assign cdb_valid_out = valid_q;
    assign cdb_tag_out   = tag_q;
    assign cdb_value_out = value_q;
    assign cdb_src_out   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized
// run against a queue-based model of the arbitration rules.
module tb_cdb_arbiter;

    localparam int N  = 2;
    localparam int D  = 2;
    localparam int TW = 4;
    localparam int XL = 32;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rdy_in = 1'b1;
    logic            clear_in = 1'b0;
    logic [N-1:0]    src_valid_in = '0;
    logic [N*TW-1:0] src_tag_in = '0;
    logic [N*XL-1:0] src_value_in = '0;
    logic [N-1:0]    src_ready_out;
    logic            cdb_valid_out;
    logic [TW-1:0]   cdb_tag_out;
    logic [XL-1:0]   cdb_value_out;
    logic [0:0]      cdb_src_out;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .NUM_SRC   (N),
        .DEPTH     (D),
        .ROB_TAG_W (TW),
        .XLEN      (XL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy_in        (rdy_in),
        .clear_in      (clear_in),
        .src_valid_in  (src_valid_in),
        .src_tag_in    (src_tag_in),
        .src_value_in  (src_value_in),
        .src_ready_out (src_ready_out),
        .cdb_valid_out (cdb_valid_out),
        .cdb_tag_out   (cdb_tag_out),
        .cdb_value_out (cdb_value_out),
        .cdb_src_out   (cdb_src_out)
    );

    // Reference model: one queue per source plus the broadcast register.
    logic [TW+XL-1:0] mq [N][$];
    int               m_rr;
    logic             m_valid;
    logic [TW-1:0]    m_tag;
    logic [XL-1:0]    m_value;
    int               m_src;

    int n_tests = 0;
    int n_fail  = 0;
    int n_proto = 0;
    int o_tag[$];
    int o_src[$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rr = N - 1; m_valid = 1'b0; m_tag = '0; m_value = '0; m_src = 0;
    endfunction

    function automatic bit m_ready(int i);
        return mq[i].size() < D;
    endfunction

    // Apply the rules for one clock edge given the currently driven inputs.
    function automatic void model_step();
        bit rdyv [N];
        int win;
        bit byp;
        logic [TW+XL-1:0] e;
        if (clear_in) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 1'b0;
            return;
        end
        if (!rdy_in) return;
        for (int i = 0; i < N; i++) rdyv[i] = (mq[i].size() < D);
        win = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (win < 0 && (mq[i].size() > 0 || (BYP && src_valid_in[i] && rdyv[i]))) win = i;
        end
        byp = 1'b0;
        if (win >= 0) begin
            if (mq[win].size() > 0) e = mq[win].pop_front();
            else begin
                e = {src_tag_in[win*TW +: TW], src_value_in[win*XL +: XL]};
                byp = 1'b1;
            end
            m_valid = 1'b1; m_tag = e[TW+XL-1:XL]; m_value = e[XL-1:0];
            m_src = win; m_rr = win;
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (src_valid_in[i] && !rdyv[i]) n_proto++;
            if (src_valid_in[i] && rdyv[i] && !(byp && win == i))
                mq[i].push_back({src_tag_in[i*TW +: TW], src_value_in[i*XL +: XL]});
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input bit v, input logic [TW-1:0] t, input logic [XL-1:0] val);
        src_valid_in[i]          = v;
        src_tag_in[i*TW +: TW]   = t;
        src_value_in[i*XL +: XL] = val;
    endtask

    task automatic idle();
        src_valid_in = '0;
        clear_in     = 1'b0;
        rdy_in       = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Push per-source tag lists, retrying until accepted, and record the CDB stream.
    task automatic run_stream(input int t0[$], input int t1[$], output bit timeout);
        bit acc0, acc1;
        o_tag.delete(); o_src.delete();
        timeout = 1'b1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (t0.size() > 0) set_in(0, 1'b1, TW'(t0[0]), 32'h1000_0000 + t0[0]);
            else               set_in(0, 1'b0, '0, '0);
            if (t1.size() > 0) set_in(1, 1'b1, TW'(t1[0]), 32'h2000_0000 + t1[0]);
            else               set_in(1, 1'b0, '0, '0);
            acc0 = src_valid_in[0] && m_ready(0);
            acc1 = src_valid_in[1] && m_ready(1);
            tick();
            if (acc0) void'(t0.pop_front());
            if (acc1) void'(t1.pop_front());
            if (cdb_valid_out) begin
                o_tag.push_back(int'(cdb_tag_out));
                o_src.push_back(int'(cdb_src_out));
            end
            if (t0.size() == 0 && t1.size() == 0 && mq[0].size() == 0 && mq[1].size() == 0 && !m_valid) begin
                timeout = 1'b0;
                break;
            end
        end
        src_valid_in = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out} !== {1'b0, 4'h0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b t=%0h val=%0h s=%0d, want all zero",
                     cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out);
        end
        n_tests++;
        if (src_ready_out !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got %b want 11", src_ready_out);
        end
        set_in(0, 1'b1, 4'h1, 32'h11); set_in(1, 1'b1, 4'h2, 32'h22);
        tick(); tick();
        idle();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out, src_ready_out} !== {1'b0, 4'h0, 32'h0, 1'b0, 2'b11}) begin
            n_fail++;
            $display("FAIL midop_reset: got v=%0b t=%0h val=%0h s=%0d rdy=%b, want zeros rdy=11",
                     cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out, src_ready_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tick();
        n_tests++;
        if (cdb_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_lost_results: got valid=%0b want 0", cdb_valid_out);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_in(0, 1'b1, 4'd3, 32'hDEADBEEF);
        tick();
        idle();
        if (!BYP) begin
            n_tests++;
            if (cdb_valid_out !== 1'b0) begin
                n_fail++; $display("FAIL single_latency: valid after 1 edge got %0b want 0", cdb_valid_out);
            end
            tick();
        end
        n_tests++;
        if ({cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out} !== {1'b1, 4'd3, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL single_bcast: got v=%0b t=%0d val=%0h s=%0d want v=1 t=3 val=deadbeef s=0",
                     cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out);
        end
        tick();
        n_tests++;
        if (cdb_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL single_drop: got valid=%0b want 0", cdb_valid_out);
        end
    endtask

    task automatic test_alternate();
        int a[$]; int b[$]; bit to;
        int exp_t [6] = '{1, 2, 1, 2, 1, 2};
        do_reset();
        for (int k = 0; k < 3; k++) begin a.push_back(1); b.push_back(2); end
        run_stream(a, b, to);
        n_tests++;
        if (to || o_tag.size() != 6) begin
            n_fail++; $display("FAIL alt_count: got %0d broadcasts timeout=%0b want 6", o_tag.size(), to);
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_tests++;
                if (o_tag[k] != exp_t[k] || o_src[k] != exp_t[k] - 1) begin
                    n_fail++;
                    $display("FAIL alt_order[%0d]: got tag=%0d src=%0d want tag=%0d src=%0d",
                             k, o_tag[k], o_src[k], exp_t[k], exp_t[k] - 1);
                end
            end
        end
    endtask

    task automatic test_src1_stream();
        int a[$]; int b[$]; bit to;
        do_reset();
        for (int k = 0; k < 3; k++) b.push_back(5 + k);
        run_stream(a, b, to);
        n_tests++;
        if (to || o_tag.size() != 3) begin
            n_fail++; $display("FAIL src1_count: got %0d broadcasts timeout=%0b want 3", o_tag.size(), to);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (o_tag[k] != 5 + k || o_src[k] != 1) begin
                    n_fail++;
                    $display("FAIL src1_order[%0d]: got tag=%0d src=%0d want tag=%0d src=1", k, o_tag[k], o_src[k], 5 + k);
                end
            end
        end
    endtask

    task automatic test_full();
        int acc1[$]; int got1[$]; bit found; bit seen15;
        do_reset();
        o_tag.delete(); o_src.delete();
        found = 1'b0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            set_in(0, 1'b1, TW'(cyc), 32'h0A00_0000 + cyc);
            if (!m_ready(1)) begin found = 1'b1; break; end
            set_in(1, 1'b1, TW'(8 + cyc), 32'h0B00_0000 + cyc);
            acc1.push_back(8 + cyc);
            tick();
            if (cdb_valid_out) begin o_tag.push_back(int'(cdb_tag_out)); o_src.push_back(int'(cdb_src_out)); end
        end
        n_tests++;
        if (!found || src_ready_out[1] !== 1'b0) begin
            n_fail++; $display("FAIL full_ready: got ready1=%0b filled=%0b want ready1=0", src_ready_out[1], found);
        end
        set_in(1, 1'b1, 4'd15, 32'hBAD0_BAD0);
        tick();
        if (cdb_valid_out) begin o_tag.push_back(int'(cdb_tag_out)); o_src.push_back(int'(cdb_src_out)); end
        idle();
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cdb_valid_out) begin o_tag.push_back(int'(cdb_tag_out)); o_src.push_back(int'(cdb_src_out)); end
        end
        seen15 = 1'b0;
        for (int k = 0; k < o_tag.size(); k++) begin
            if (o_tag[k] == 15) seen15 = 1'b1;
            if (o_src[k] == 1) got1.push_back(o_tag[k]);
        end
        n_tests++;
        if (seen15) begin
            n_fail++; $display("FAIL full_drop: dropped tag 15 got broadcast, want never");
        end
        n_tests++;
        if (got1 != acc1) begin
            n_fail++; $display("FAIL full_src1_seq: got %0d src1 results want %0d in push order", got1.size(), acc1.size());
        end
    endtask

    task automatic test_clear();
        do_reset();
        set_in(0, 1'b1, 4'd1, 32'h1); set_in(1, 1'b1, 4'd2, 32'h2);
        tick();
        set_in(0, 1'b1, 4'd3, 32'h3); set_in(1, 1'b1, 4'd4, 32'h4);
        tick();
        n_tests++;
        if (cdb_valid_out !== 1'b1) begin
            n_fail++; $display("FAIL clear_pre_valid: got %0b want 1", cdb_valid_out);
        end
        idle();
        clear_in = 1'b1;
        rdy_in   = 1'b0;
        tick();
        idle();
        n_tests++;
        if (cdb_valid_out !== 1'b0 || src_ready_out !== 2'b11) begin
            n_fail++; $display("FAIL clear_now: got valid=%0b rdy=%b want valid=0 rdy=11", cdb_valid_out, src_ready_out);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (cdb_valid_out !== 1'b0) begin
                n_fail++; $display("FAIL clear_leak[%0d]: got valid=%0b tag=%0d want valid=0", k, cdb_valid_out, cdb_tag_out);
            end
        end
    endtask

    task automatic test_hold();
        logic          s_valid;
        logic [TW-1:0] s_tag;
        logic [XL-1:0] s_val;
        logic [N-1:0]  s_rdy;
        do_reset();
        set_in(0, 1'b1, 4'd1, 32'hA1); set_in(1, 1'b1, 4'd3, 32'hB3);
        tick();
        set_in(0, 1'b1, 4'd2, 32'hA2); set_in(1, 1'b1, 4'd4, 32'hB4);
        tick();
        s_valid = m_valid; s_tag = m_tag; s_val = m_value;
        s_rdy   = {m_ready(1), m_ready(0)};
        rdy_in = 1'b0;
        set_in(0, 1'b1, 4'd7, 32'hF7); set_in(1, 1'b1, 4'd7, 32'hF7);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (cdb_valid_out !== s_valid || cdb_tag_out !== s_tag || cdb_value_out !== s_val || src_ready_out !== s_rdy) begin
                n_fail++;
                $display("FAIL hold_frozen[%0d]: got v=%0b t=%0d val=%0h rdy=%b want v=%0b t=%0d val=%0h rdy=%b",
                         k, cdb_valid_out, cdb_tag_out, cdb_value_out, src_ready_out, s_valid, s_tag, s_val, s_rdy);
            end
        end
        idle();
        for (int k = 0; k < 6; k++) begin
            tick();
            n_tests++;
            if (cdb_valid_out !== m_valid || (m_valid && (cdb_tag_out !== m_tag || cdb_value_out !== m_value || cdb_src_out !== 1'(m_src)))) begin
                n_fail++;
                $display("FAIL hold_resume[%0d]: got v=%0b t=%0d s=%0d want v=%0b t=%0d s=%0d",
                         k, cdb_valid_out, cdb_tag_out, cdb_src_out, m_valid, m_tag, m_src);
            end
        end
    endtask

`ifdef CDB_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        set_in(0, 1'b1, 4'd9, 32'h0000_0909);
        tick();
        idle();
        n_tests++;
        if ({cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out} !== {1'b1, 4'd9, 32'h0000_0909, 1'b0}) begin
            n_fail++;
            $display("FAIL bypass_latency: got v=%0b t=%0d val=%0h s=%0d want v=1 t=9 val=909 s=0",
                     cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out);
        end
        tick();
        n_tests++;
        if (cdb_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL bypass_no_dup: got valid=%0b want 0", cdb_valid_out);
        end
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rdy_in   = ($urandom_range(0, 9) != 0);
            clear_in = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) begin
                bit v;
                v = ($urandom_range(0, 2) != 0) && (m_ready(i) || $urandom_range(0, 7) == 0);
                set_in(i, v, TW'($urandom_range(0, 15)), $urandom);
            end
            for (int i = 0; i < N; i++) exp_rdy[i] = m_ready(i);
            n_tests++;
            if (src_ready_out !== exp_rdy) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, src_ready_out, exp_rdy);
            end
            tick();
            n_tests++;
            if (cdb_valid_out !== m_valid || cdb_tag_out !== m_tag || cdb_value_out !== m_value || cdb_src_out !== 1'(m_src)) begin
                n_fail++;
                $display("FAIL rand_cdb[%0d]: got v=%0b t=%0d val=%0h s=%0d want v=%0b t=%0d val=%0h s=%0d",
                         cyc, cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out, m_valid, m_tag, m_value, m_src);
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_alternate();
        test_src1_stream();
        test_full();
        test_clear();
        test_hold();
`ifdef CDB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("[TB] note: %0d deliberate pushes while not ready were issued", n_proto);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
